// File: rtl/des_result_serializer.sv
// des_result_serializer: captures DES results after a fixed load latency,
// buffers them in a small FIFO and streams each 64-bit word as 8 bytes, MSB first.
// Ports: clk, reset (sync, active-high), load, des_data[63:0] in;
//        out_byte[7:0], out_valid, out_last, busy, overflow out; out_ready in.
// Optional: define DES_SER_PARITY_EN to add out_parity (odd parity of out_byte).
module des_result_serializer #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] des_data,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
`ifdef DES_SER_PARITY_EN
  output logic        out_parity,
`endif
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // load tracking
  logic [LATENCY-1:0] pipe;
  logic [LATENCY:0]   pipe_nxt;
  logic               capture;

  assign pipe_nxt = {pipe, load};
  assign capture  = pipe[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) pipe <= '0;
    else       pipe <= pipe_nxt[LATENCY-1:0];
  end

  // FIFO
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [0:0]  state;
  logic [63:0] sreg;
  logic [2:0]  idx;
  logic        xfer;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign xfer  = (state == SEND) && out_ready;

  // A pop at the same edge frees the slot the capture needs.
  assign pop  = !empty && ((state == IDLE) || (xfer && idx == 3'd7));
  assign push = capture && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= des_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (capture && !push) overflow <= 1'b1;
    end
  end

  // serializer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            sreg  <= mem[rd_ptr];
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx != 3'd7) begin
              sreg <= {sreg[55:0], 8'h00};
              idx  <= idx + 3'd1;
            end else if (!empty) begin
              sreg <= mem[rd_ptr];
              idx  <= '0;
            end else begin
              // clearing keeps out_byte at zero while idle
              sreg  <= '0;
              idx   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == SEND);
  assign out_byte  = sreg[63:56];
  assign out_last  = out_valid && (idx == 3'd7);
  assign busy      = (|pipe) || !empty || out_valid;

`ifdef DES_SER_PARITY_EN
  assign out_parity = out_valid & ~(^sreg[63:56]);
`endif

endmodule

// File: tb/tb_des_result_serializer.sv
// tb_des_result_serializer: directed plus random stimulus against a
// queue-based reference model of load capture, FIFO and byte streaming.
module tb_des_result_serializer;

  localparam int LAT = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] des_data;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overflow;
`ifdef DES_SER_PARITY_EN
  logic        out_parity;
`endif

  des_result_serializer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .des_data(des_data),
    .out_byte(out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
`ifdef DES_SER_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [63:0] q[$];
  int          loads[$];
  logic [63:0] cur;
  int          nsent;
  bit          active;
  bit          ovf;
  bit          after_rst;
  int          cyc;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte();
    logic [63:0] w;
    w = cur << (8 * nsent);
    return w[63:56];
  endfunction

  task automatic compare();
    logic [7:0] b;
    b = exp_byte();
    check("out_valid", {63'd0, out_valid}, {63'd0, active});
    if (active)
      check("out_byte", {56'd0, out_byte}, {56'd0, b});
    else if (after_rst)
      check("out_byte_rst", {56'd0, out_byte}, 64'd0);
    check("out_last", {63'd0, out_last}, {63'd0, active && nsent == 7});
    check("busy", {63'd0, busy},
          {63'd0, loads.size() > 0 || q.size() > 0 || active});
    check("overflow", {63'd0, overflow}, {63'd0, ovf});
`ifdef DES_SER_PARITY_EN
    check("out_parity", {63'd0, out_parity},
          {63'd0, active && ($countones(b) % 2 == 0)});
`endif
  endtask

  task automatic model_reset();
    q.delete();
    loads.delete();
    cur       = '0;
    nsent     = 0;
    active    = 0;
    ovf       = 0;
    after_rst = 1;
  endtask

  task automatic model(bit rs, bit ld, logic [63:0] d, bit rdy);
    bit          cap;
    bit          xfer;
    bit          popped;
    bit          was_full;
    logic [63:0] w;
    cyc++;
    if (rs) begin
      model_reset();
      return;
    end
    after_rst = 0;
    w        = '0;
    cap      = loads.size() > 0 && loads[0] + LAT == cyc;
    xfer     = active && rdy;
    was_full = q.size() == DEP;
    popped   = q.size() > 0 && (!active || (xfer && nsent == 7));
    if (popped) w = q.pop_front();
    if (cap) begin
      void'(loads.pop_front());
      if (was_full && !popped) ovf = 1;
      else q.push_back(d);
    end
    if (ld) loads.push_back(cyc);
    if (!active) begin
      if (popped) begin
        cur = w; nsent = 0; active = 1;
      end
    end else if (xfer) begin
      if (nsent < 7) nsent++;
      else if (popped) begin
        cur = w; nsent = 0;
      end else active = 0;
    end
  endtask

  task automatic step(bit rs, bit ld, logic [63:0] d, bit rdy);
    @(negedge clk);
    compare();
    reset     = rs;
    load      = ld;
    des_data  = d;
    out_ready = rdy;
    @(posedge clk);
    model(rs, ld, d, rdy);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] w;
    cyc       = 0;
    reset     = 1'b1;
    load      = 1'b0;
    des_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 0, '0, 0);

    // single word
    w = 64'h85E813540F0AB405;
    step(0, 1, w, 1);
    repeat (13) step(0, 0, w, 1);

    // backpressure
    step(0, 1, w, 1);
    for (int i = 0; i < 30; i++) step(0, 0, w, (i % 3) == 2);

    // back-to-back
    step(0, 1, rnd64(), 1);
    step(0, 1, rnd64(), 1);
    step(0, 1, 64'h1111111111111111, 1);
    step(0, 0, 64'h2222222222222222, 1);
    step(0, 0, 64'h3333333333333333, 1);
    repeat (26) step(0, 0, rnd64(), 1);

    // overflow
    for (int i = 0; i < 6; i++) step(0, 1, rnd64(), 0);
    repeat (4) step(0, 0, rnd64(), 0);
    repeat (48) step(0, 0, rnd64(), 1);
    step(1, 0, '0, 1);

    // reset mid-word with a load in flight
    step(0, 1, w, 1);
    repeat (6) step(0, 0, w, 1);
    step(0, 1, w, 1);
    step(1, 0, w, 1);
    repeat (10) step(0, 0, w, 1);

    // parity bytes 85, 00, FF
    step(0, 1, 64'h8500FF0000000000, 1);
    repeat (2) step(0, 0, 64'h8500FF0000000000, 1);
    repeat (10) step(0, 0, '0, 1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit burst;
      burst = (i / 100) % 2 == 1;
      step(($urandom % 250) == 0,
           burst ? ($urandom % 2 == 0) : ($urandom % 7 == 0),
           rnd64(),
           ($urandom % 4) != 0);
    end
    repeat (60) step(0, 0, rnd64(), 1);
    step(0, 0, '0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
